// File: rtl/coef_bank_seq_if.sv
// Coefficient stream from coef_bank_seq to the downstream MAC: valid/ready beats
// tagged with their index, plus the end-of-frame pulse.
interface coef_bank_seq_if #(
    parameter int W     = 25,
    parameter int NCOEF = 8
);
    logic [W-1:0]             coef;
    logic [$clog2(NCOEF)-1:0] coef_idx;
    logic                     coef_valid;
    logic                     coef_ready;
    logic                     frame_done;

    modport master (output coef, coef_idx, coef_valid, frame_done, input coef_ready);
    modport slave  (input coef, coef_idx, coef_valid, frame_done, output coef_ready);
endinterface

// File: rtl/coef_bank_seq.sv
// Multi-profile coefficient bank streaming one profile per frame over valid/ready.
// Define COEF_WRITE_EN for the runtime write port; otherwise the bank is a constant ROM.
module coef_bank_seq #(
    parameter  int W     = 25,
    parameter  int NCOEF = 8,
    parameter  int NPROF = 4,
    localparam int PW    = (NPROF > 1) ? $clog2(NPROF) : 1,
    localparam int IW    = $clog2(NCOEF)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [PW-1:0]        prof_sel,
    input  logic                 start,
    output logic                 busy,
    output logic [PW-1:0]        prof_active,
    coef_bank_seq_if.master      cs
`ifdef COEF_WRITE_EN
    ,
    input  logic                 wr_en,
    input  logic [PW-1:0]        wr_prof,
    input  logic [IW-1:0]        wr_idx,
    input  logic [W-1:0]         wr_data,
    output logic                 wr_err
`endif
);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                                state_q, state_d;
    logic [PW-1:0]                         prof_q, prof_d, sel_map;
    logic [IW-1:0]                         idx_q, idx_d, idx_inc;
    logic [W-1:0]                          coef_q, coef_d;
    logic                                  done_q, done_d;
    logic [NPROF-1:0][NCOEF-1:0][W-1:0]    bank;

    function automatic logic [W-1:0] def_coef(input int p, input int i);
        logic [W-1:0] v;
        v = '0;
        if (p == 0) begin
            case (i)
                0: v = W'(32'h0004000);
                1: v = W'(32'h000423D);
                2: v = W'(32'h1FFE876);
                5: v = W'(32'h0000552);
                6: v = W'(32'h0000AA5);
                7: v = W'(32'h0000552);
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    // Out-of-range profile requests fall back to profile 0.
    assign sel_map = (32'(prof_sel) >= NPROF) ? '0 : prof_sel;
    assign idx_inc = idx_q + 1'b1;

`ifdef COEF_WRITE_EN
    logic start_acc, wr_bad, err_q;

    assign start_acc = (state_q == IDLE) && start;
    // Never modify the profile being streamed or about to be streamed.
    assign wr_bad = (32'(wr_prof) >= NPROF) || (32'(wr_idx) >= NCOEF) ||
                    (busy && (wr_prof == prof_q)) ||
                    (start_acc && (wr_prof == sel_map));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
            for (int p = 0; p < NPROF; p++)
                for (int i = 0; i < NCOEF; i++)
                    bank[p][i] <= def_coef(p, i);
        end else begin
            err_q <= wr_en && wr_bad;
            if (wr_en && !wr_bad)
                bank[wr_prof][wr_idx] <= wr_data;
        end
    end

    assign wr_err = err_q;
`else
    for (genvar p = 0; p < NPROF; p++) begin : g_prof
        for (genvar i = 0; i < NCOEF; i++) begin : g_idx
            assign bank[p][i] = def_coef(p, i);
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        prof_d  = prof_q;
        idx_d   = idx_q;
        coef_d  = coef_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                    prof_d  = sel_map;
                    idx_d   = '0;
                    coef_d  = bank[sel_map][0];
                end
            end
            STREAM: begin
                if (cs.coef_ready) begin
                    if (idx_q == IW'(NCOEF - 1)) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        coef_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d  = idx_inc;
                        coef_d = bank[prof_q][idx_inc];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            prof_q  <= '0;
            idx_q   <= '0;
            coef_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prof_q  <= prof_d;
            idx_q   <= idx_d;
            coef_q  <= coef_d;
            done_q  <= done_d;
        end
    end

    assign busy          = (state_q == STREAM);
    assign prof_active   = prof_q;
    assign cs.coef_valid = (state_q == STREAM);
    assign cs.coef       = coef_q;
    assign cs.coef_idx   = idx_q;
    assign cs.frame_done = done_q;

endmodule
